// File: rtl/core_mem_arbiter.sv
// Single-port memory arbiter between the fetch and data stages: one registered command per access.
// Optional fetch-fairness streak limiter is enabled by defining MEM_ARB_FAIR_EN.
module core_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int MAX_D_STREAK = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_cancel,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_req_f,
    output logic              stall_req_m,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MEM_LATENCY < 1 || MAX_D_STREAK < 1) begin : g_param_check
        $error("core_mem_arbiter: MEM_LATENCY and MAX_D_STREAK must both be >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            state_q;
    logic              owner_d_q;   // 1: data stage owns the current access
    logic              cancel_q;
    logic              mem_valid_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              i_done_q;
    logic              d_done_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;

    logic fetch_ok;
    logic force_f;
    logic grant_d;
    logic grant_f;

    always_comb begin
        fetch_ok = i_req & ~i_cancel;
        grant_d  = (state_q == S_IDLE) && d_req && !force_f;
        grant_f  = (state_q == S_IDLE) && fetch_ok && !grant_d;
    end

`ifdef MEM_ARB_FAIR_EN
    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    always_comb begin
        force_f  = fetch_ok && (streak_q >= STREAK_W'(MAX_D_STREAK));
        streak_d = streak_q;
        if (!i_req || grant_f) begin
            streak_d = '0;
        end else if (grant_d && (streak_q < STREAK_W'(MAX_D_STREAK))) begin
            streak_d = streak_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end
`else
    always_comb force_f = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            owner_d_q   <= 1'b0;
            cancel_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            // NOTE: strobes default low here so each one is high for exactly one cycle.
            mem_valid_q <= 1'b0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_d || grant_f) begin
                        state_q     <= S_ISSUE;
                        owner_d_q   <= grant_d;
                        cancel_q    <= 1'b0;
                        mem_valid_q <= 1'b1;
                        mem_we_q    <= grant_d & d_we;
                        mem_addr_q  <= grant_d ? d_addr : i_addr;
                        mem_wdata_q <= grant_d ? d_wdata : '0;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
                    if (!owner_d_q && i_cancel) begin
                        cancel_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (!owner_d_q && i_cancel) begin
                        cancel_q <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        state_q <= S_RESP;
                        if (owner_d_q) begin
                            d_done_q <= 1'b1;
                            if (!mem_we_q) begin
                                d_rdata_q <= mem_rdata;
                            end
                        end else if (!cancel_q && !i_cancel) begin
                            // A flushed fetch still drains the memory but is never reported.
                            i_done_q  <= 1'b1;
                            i_rdata_q <= mem_rdata;
                        end
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign i_done      = i_done_q;
    assign d_done      = d_done_q;
    assign i_rdata     = i_rdata_q;
    assign d_rdata     = d_rdata_q;
    assign mem_valid   = mem_valid_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign stall_req_f = i_req & ~i_done_q & ~i_cancel;
    assign stall_req_m = d_req & ~d_done_q;

endmodule
